// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// 32-byte blocks and a single outstanding miss. While a miss is serviced the
// pipeline is frozen and the request is held stable on the p1_* inputs.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int unsigned LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [255:0] mem_data_o,
  output logic [31:0]  mem_addr_o,
  output logic         mem_enable_o,
  output logic         mem_write_o
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 32 - 5 - IW;

  typedef enum logic [2:0] {StIdle, StMiss, StWriteback, StRefill, StRefilled} state_e;

  state_e state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [255:0]     data_q [LINES];

  logic [2:0]    word;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          req;
  logic          hit;
  logic          refill_done;
  logic          store_hit;

  // Byte offset within a word is irrelevant for word accesses.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^p1_addr_i[1:0];

  assign word = p1_addr_i[4:2];
  assign idx  = p1_addr_i[5 +: IW];
  assign tag  = p1_addr_i[31 -: TW];

  assign req         = p1_MemRead_i | p1_MemWrite_i;
  assign hit         = req & valid_q[idx] & (tag_q[idx] == tag);
  assign p1_stall_o  = req & ((state_q != StIdle) | ~hit);
  assign refill_done = (state_q == StRefill) & mem_ack_i;
  assign store_hit   = (state_q == StIdle) & p1_MemWrite_i & hit;

  // Load data is returned in the same cycle as the hit.
  always_comb begin
    p1_data_o = '0;
    if (p1_MemRead_i && hit) begin
      p1_data_o = data_q[idx][{word, 5'b0} +: 32];
    end
  end

  // Next-state logic and Moore memory-side outputs.
  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    unique case (state_q)
      StIdle: begin
        if (req && !hit) state_d = StMiss;
      end
      StMiss: begin
        state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StRefill;
      end
      StWriteback: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx], idx, 5'b0};
        mem_data_o   = data_q[idx];
        if (mem_ack_i) state_d = StRefill;
      end
      StRefill: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {p1_addr_i[31:5], 5'b0};
        if (mem_ack_i) state_d = StRefilled;
      end
      StRefilled: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Line status bits: refill installs a clean line, a store hit dirties it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill_done) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (store_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (refill_done) begin
        tag_q[idx]  <= tag;
        data_q[idx] <= mem_data_i;
      end else if (store_hit) begin
        data_q[idx][{word, 5'b0} +: 32] <= p1_data_i;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StIdle) begin
      if (hit && !p1_stall_o) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (req && !hit)        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl (default 32 lines). Expected behaviour
// comes from a line-level cache model plus a backing memory of blocks.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_ctrl #(.LINES(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_MemRead_i (p1_MemRead_i),
    .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .mem_data_o   (mem_data_o),
    .mem_addr_o   (mem_addr_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: cache lines plus backing memory indexed by block number.
  logic         m_valid [32];
  logic         m_dirty [32];
  logic [21:0]  m_tag   [32];
  logic [255:0] m_data  [32];
  logic [255:0] backing [logic [26:0]];
  int unsigned  exp_hits;
  int unsigned  exp_misses;

  function automatic logic [255:0] fetch(input logic [26:0] blk);
    if (!backing.exists(blk)) begin
      backing[blk] = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
    end
    return backing[blk];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // Issue one request at a negedge, play memory with a fixed ack latency,
  // and compare stall length, memory transactions and load data to the model.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat);
    int           idx;
    int           w;
    bit           exp_hit;
    bit           exp_wb;
    int           exp_stall;
    int           stalls;
    int           en_cnt;
    int           guard;
    bit           seen_wb;
    logic [31:0]  victim_addr;
    logic [255:0] line;
    idx         = int'(addr[9:5]);
    w           = int'(addr[4:2]);
    exp_hit     = m_valid[idx] && (m_tag[idx] == addr[31:10]);
    exp_wb      = !exp_hit && m_valid[idx] && m_dirty[idx];
    exp_stall   = exp_hit ? 0 : 3 + lat + (exp_wb ? lat : 0);
    victim_addr = {m_tag[idx], addr[9:5], 5'b0};

    p1_addr_i     = addr;
    p1_data_i     = wdata;
    p1_MemRead_i  = !wr;
    p1_MemWrite_i = wr;
    stalls  = 0;
    en_cnt  = 0;
    guard   = 0;
    seen_wb = 1'b0;
    #1;
    while (p1_stall_o && guard < 500) begin
      stalls++;
      guard++;
      if (mem_enable_o) begin
        en_cnt++;
        if (en_cnt == 1) begin
          if (mem_write_o) begin
            seen_wb = 1'b1;
            check("wb_addr", mem_addr_o, victim_addr);
            check("wb_data", mem_data_o, m_data[idx]);
          end else begin
            check("refill_addr", mem_addr_o, {addr[31:5], 5'b0});
          end
        end
        if (en_cnt == lat) begin
          mem_ack_i = 1'b1;
          if (mem_write_o) mem_data_i = '0;
          else             mem_data_i = fetch(addr[31:5]);
          en_cnt = 0;
        end
      end
      @(negedge clk);
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      #1;
    end
    if (guard >= 500) check("timeout", 1'b1, 1'b0);
    check("stall_cycles", stalls, exp_stall);
    check("writeback_seen", seen_wb, exp_wb);

    // Update model: evict, allocate, then apply the access.
    if (!exp_hit) begin
      exp_misses++;
      if (exp_wb) backing[victim_addr[31:5]] = m_data[idx];
      m_data[idx]  = fetch(addr[31:5]);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = addr[31:10];
    end
    exp_hits++;
    line = m_data[idx];
    if (wr) begin
      line[w*32 +: 32] = wdata;
      m_data[idx]      = line;
      m_dirty[idx]     = 1'b1;
    end else begin
      check("load_data", p1_data_o, line[w*32 +: 32]);
    end
    @(negedge clk);
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    #1;
  endtask

  initial begin
    logic [255:0] blk;
    logic [31:0]  a;
    rst_i         = 1'b1;
    p1_addr_i     = '0;
    p1_data_i     = '0;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    mem_data_i    = '0;
    mem_ack_i     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("rst_stall", p1_stall_o, 1'b0);
    check("rst_mem_en", mem_enable_o, 1'b0);
    check("rst_mem_wr", mem_write_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_p1_data", p1_data_o, 32'h0);

    // Cold load with 10-cycle memory: 13 stall cycles.
    blk = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), 32'h11111111};
    backing[27'h2] = blk;
    do_req(1'b0, 32'h0000_0040, 32'h0, 10);
    // Store hit then load hit.
    do_req(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 3);
    do_req(1'b0, 32'h0000_0044, 32'h0, 3);
    // Conflict miss on dirty line: write-back to 0x40 then refill 0x440.
    do_req(1'b0, 32'h0000_0440, 32'h0, 4);
    check("wb_word1", backing[27'h2][63:32], 32'hDEAD_BEEF);

    // Reset during refill abandons the transaction; late ack is ignored.
    p1_addr_i    = 32'h0000_0840;
    p1_MemRead_i = 1'b1;
    #1;
    for (int i = 0; i < 20 && !(mem_enable_o && !mem_write_o); i++) begin
      @(negedge clk);
      #1;
    end
    check("mid_refill_reached", mem_enable_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i        = 1'b0;
    p1_MemRead_i = 1'b0;
    mem_ack_i    = 1'b1;
    mem_data_i   = {8{32'hBAD0_BAD0}};
    #1;
    check("post_rst_mem_en", mem_enable_o, 1'b0);
    check("post_rst_stall", p1_stall_o, 1'b0);
    @(negedge clk);
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    #1;
    check("late_ack_mem_en", mem_enable_o, 1'b0);
    model_reset();
    do_req(1'b0, 32'h0000_0840, 32'h0, 2);

    // Spurious ack in idle must change nothing.
    mem_ack_i  = 1'b1;
    mem_data_i = {8{$urandom()}};
    #1;
    check("spur_mem_en", mem_enable_o, 1'b0);
    check("spur_stall", p1_stall_o, 1'b0);
    @(negedge clk);
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    #1;
    do_req(1'b0, 32'h0000_0840, 32'h0, 2);

    // Random traffic over a few indices and tags to force conflicts.
    for (int n = 0; n < 300; n++) begin
      a = '0;
      a[11:10] = 2'($urandom_range(0, 3));
      a[6:5]   = 2'($urandom_range(0, 3));
      a[4:2]   = 3'($urandom_range(0, 7));
      do_req(1'($urandom_range(0, 1)), a, $urandom(), $urandom_range(1, 6));
    end

`ifdef DCACHE_STATS_EN
    check("hit_cnt", hit_cnt_o, exp_hits);
    check("miss_cnt", miss_cnt_o, exp_misses);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
